// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU data port and DMA/loader port.
// Each GNT cycle performs exactly one access and the FSM always falls back to IDLE before the next one.
module ram_arbiter_port (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt_i,
  input  logic        we_i,
  input  logic        bad_i,
  input  logic [31:0] dato_s_i,
  output logic        err_o,
  output logic [31:0] rdata_o
);
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // A rejected access still updates err but leaves the read data untouched.
  always_comb begin
    err_d   = err_q;
    rdata_d = rdata_q;
    if (gnt_i) begin
      err_d = bad_i;
      if (!we_i && !bad_i) rdata_d = dato_s_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign err_o   = err_q;
  assign rdata_o = rdata_q;
endmodule

module ram_arbiter #(
  parameter int          PRIO_CPU = 0,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned ADDR_MSB = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic        MemWrite,
  output logic [31:0] dato_e,
  output logic [31:0] direccion,
  input  logic [31:0] dato_s
);
  localparam int NUM_PORTS = 2;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_e;

  state_e     state_q, state_d;
  logic       last_dma_q, last_dma_d;
  logic [3:0] wait_q, wait_d;
  logic       pick_dma;

  logic [NUM_PORTS-1:0]       req, we, gnt, bad, err;
  logic [NUM_PORTS-1:0][31:0] addr, wdata, rdata;

  assign req   = {dma_req, cpu_req};
  assign we    = {dma_we, cpu_we};
  assign addr  = {dma_addr, cpu_addr};
  assign wdata = {dma_wdata, cpu_wdata};
  assign gnt   = {state_q == GNT_DMA, state_q == GNT_CPU};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign bad[p] = (addr[p][31:ADDR_MSB+1] != '0) | (addr[p][1:0] != 2'b00);
    ram_arbiter_port u_port (
      .clk_i    (clk),
      .rst_i    (reset),
      .gnt_i    (gnt[p]),
      .we_i     (we[p]),
      .bad_i    (bad[p]),
      .dato_s_i (dato_s),
      .err_o    (err[p]),
      .rdata_o  (rdata[p])
    );
  end

  // wait_q counts CPU wins against a pending DMA; at WAIT_MAX the DMA is forced through.
  always_comb begin
    state_d    = IDLE;
    last_dma_d = last_dma_q;
    wait_d     = wait_q;
    pick_dma   = 1'b0;
    if (state_q == IDLE) begin
      if (req == 2'b11) pick_dma = (PRIO_CPU != 0) ? (wait_q == WAIT_MAX) : !last_dma_q;
      else              pick_dma = req[1];
      if (req != 2'b00) begin
        state_d    = pick_dma ? GNT_DMA : GNT_CPU;
        last_dma_d = pick_dma;
      end
      if (!req[1] || pick_dma)     wait_d = '0;
      else if (wait_q != WAIT_MAX) wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_dma_q <= 1'b1;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    MemWrite  = 1'b0;
    direccion = '0;
    dato_e    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        direccion = addr[p];
        dato_e    = wdata[p];
        MemWrite  = we[p] & ~bad[p];
      end
    end
  end

  assign cpu_ack   = gnt[0];
  assign dma_ack   = gnt[1];
  assign cpu_err   = err[0];
  assign dma_err   = err[1];
  assign cpu_rdata = rdata[0];
  assign dma_rdata = rdata[1];
endmodule
